mem_mmio: RTL and testbench
===========================

# mem_mmio

Memory-stage data slave for the pipelined ARM core: it consumes the core's `ALUOutM`, `WriteDataM` and `MemWriteM` and returns `ReadDataM` in the same cycle. It contains a word RAM, a free-running timer with a compare interrupt, and a FIFO-buffered 8N1 UART transmitter. It sits directly downstream of the core's M stage and replaces the plain data memory.

## Interface
- `RAM_WORDS`, 64: data RAM depth in 32-bit words; power of two, 16..1024.
- `CLK_DIV`, 434: clock cycles per UART bit; minimum 2.
- `FIFO_DEPTH`, 4: UART TX FIFO entries; power of two.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ALUOutM`  in  32  byte address from the core; bits [1:0] ignored.
- `WriteDataM`  in  32  store data.
- `MemWriteM`  in  1  store strobe for the current cycle.
- `ReadDataM`  out  32  combinational read data for `ALUOutM`.
- `TxD`  out  1  UART serial output; idle high.
- `IrqTimer`  out  1  sticky timer-match flag.

## Operation
Address map, decoded on the full 32 bits:
- `0x0000_0000` .. `RAM_WORDS*4-1`: RAM, indexed by `ALUOutM[log2(RAM_WORDS)+1:2]`. Contents are not reset.
- `0xFFFF_0000` TCOUNT (R/W): increments by 1 every cycle and wraps at 2^32. A write loads `WriteDataM`, and the write takes priority over the increment.
- `0xFFFF_0004` TCMP (R/W): compare value.
- `0xFFFF_0008` TSTAT: a read returns `{31'b0, IrqTimer}`. A write with bit0=1 clears `IrqTimer`.
- `0xFFFF_0010` UDATA: a write pushes `WriteDataM[7:0]` into the TX FIFO. Reads return 0.
- `0xFFFF_0014` USTAT (read): bit0 = full, bit1 = empty, bit2 = busy (FSM not IDLE), bit3 = overflow. A write with bit3=1 clears overflow.
- Any other address: reads return 0, writes are ignored, and nothing faults.

Timer:
- If TCOUNT == TCMP in a cycle, `IrqTimer` is set at the next edge.
- If the set and a TSTAT clear occur in the same cycle, the set wins.

TX FIFO:
- A push is accepted if the FIFO is not full, or if the FSM pops in the same cycle.
- Otherwise the byte is dropped and overflow is set.
- If a push and a pop occur together, the occupancy is unchanged.

TX FSM (states IDLE, START, DATA, STOP):
- IDLE: if the FIFO is non-empty, pop into the shift register, clear the bit counter, go to START. Otherwise `TxD` = 1.
- START: `TxD` = 0 for `CLK_DIV` cycles, then go to DATA.
- DATA: send 8 bits LSB first, `CLK_DIV` cycles each, then go to STOP.
- STOP: `TxD` = 1 for `CLK_DIV` cycles, then go to IDLE.
- `TxD` is driven from a register, so it is glitch-free.

## Timing
- Reset values: `TxD` = 1, `IrqTimer` = 0. TCOUNT, TCMP, the FIFO pointers and overflow are 0. FSM is IDLE, so USTAT = 0x2.
- `ReadDataM` depends only on `ALUOutM` and the current register/RAM state. It is a zero-latency combinational path.
- Reads have no side effects.
- Writes commit at the rising edge in which `MemWriteM` = 1. A same-cycle read of that address returns the old value.
- The TCOUNT value read in a cycle is the pre-increment value.
- UART frame:
  - The first frame starts one edge after the push, plus one cycle in IDLE.
  - Start bit low for exactly `CLK_DIV` cycles; each frame is 10×`CLK_DIV` cycles.
  - Back-to-back frames have exactly one IDLE cycle (`TxD` = 1) between the end of STOP and the next start bit.
- Reset mid-frame: `TxD` returns to 1 immediately (asynchronous). FIFO contents are discarded and RAM contents are kept.

## Test plan
- Reset, then read USTAT, TSTAT and `0x1234_0000` → 0x2, 0x0, 0x0; `TxD` = 1.
- Store 0xDEADBEEF to 0x8, then load from 0x8 and from 0xB → both return 0xDEADBEEF. Store to 0x8000 → RAM is unchanged and the load returns 0.
- Write TCMP = 20, then TCOUNT = 10 → `IrqTimer` rises exactly 11 cycles after the TCOUNT write edge. Write TSTAT = 1 → `IrqTimer` = 0 next cycle and stays 0 until TCOUNT wraps back to 20.
- With `CLK_DIV` = 4, push 0xA5 → `TxD` shows start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each held 4 cycles, 40 cycles in total. USTAT bit2 = 1 throughout the frame.
- Push 6 bytes back-to-back with `FIFO_DEPTH` = 4 → 5 accepted (first popped immediately) and 1 dropped; USTAT bit3 = 1. Five frames go out, each separated by one idle cycle. Write USTAT = 0x8 → bit3 clears.
- Assert `reset` low mid-DATA → `TxD` = 1 asynchronously and USTAT = 0x2 after release; a RAM word written before reset reads back unchanged.

Source files
------------

// File: rtl/mem_mmio.sv
// rtl/mem_mmio.sv - memory-stage data slave: word RAM, compare timer and FIFO-buffered 8N1 UART transmitter
module mem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    output logic [31:0] ReadDataM,
    output logic        TxD,
    output logic        IrqTimer
);
    localparam int AW    = $clog2(RAM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [31:0] ADDR_TCOUNT = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_TCMP   = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_TSTAT  = 32'hFFFF_0008;
    localparam logic [31:0] ADDR_UDATA  = 32'hFFFF_0010;
    localparam logic [31:0] ADDR_USTAT  = 32'hFFFF_0014;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

    logic [31:0]      ram [RAM_WORDS];
    logic [31:0]      tCount;
    logic [31:0]      tCmp;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] fifoCount;
    logic             overflow;
    txState_t         state;
    txState_t         stateNext;
    logic [DIV_W-1:0] divCnt;
    logic [2:0]       bitCnt;
    logic [7:0]       shiftReg;
    logic             txdReg;

    logic          ramHit;
    logic [AW-1:0] ramIdx;
    logic          ramWe;
    logic          tCountWe;
    logic          tCmpWe;
    logic          tStatClr;
    logic          pushReq;
    logic          ustatClr;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          pushOk;
    logic          pop;
    logic          bitDone;
    logic          busy;

    // RAM occupies the bottom of the map; every upper address bit must be zero
    assign ramHit    = (ALUOutM[31:AW+2] == '0);
    assign ramIdx    = ALUOutM[AW+1:2];
    assign ramWe     = MemWriteM && ramHit;
    assign tCountWe  = MemWriteM && (ALUOutM == ADDR_TCOUNT);
    assign tCmpWe    = MemWriteM && (ALUOutM == ADDR_TCMP);
    assign tStatClr  = MemWriteM && (ALUOutM == ADDR_TSTAT) && WriteDataM[0];
    assign pushReq   = MemWriteM && (ALUOutM == ADDR_UDATA);
    assign ustatClr  = MemWriteM && (ALUOutM == ADDR_USTAT) && WriteDataM[3];

    assign fifoFull  = (fifoCount == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (fifoCount == '0);
    // a full FIFO still takes a byte when the transmitter frees a slot in the same cycle
    assign pushOk    = pushReq && (!fifoFull || pop);
    assign busy      = (state != IDLE);
    assign bitDone   = (divCnt == DIV_W'(CLK_DIV - 1));
    assign TxD       = txdReg;

    // combinational read mux; reads never change state
    always_comb begin
        ReadDataM = '0;
        if (ramHit) begin
            ReadDataM = ram[ramIdx];
        end else begin
            case (ALUOutM)
                ADDR_TCOUNT: ReadDataM = tCount;
                ADDR_TCMP:   ReadDataM = tCmp;
                ADDR_TSTAT:  ReadDataM = {31'h0, IrqTimer};
                ADDR_USTAT:  ReadDataM = {28'h0, overflow, busy, fifoEmpty, fifoFull};
                default:     ReadDataM = '0;
            endcase
        end
    end

    // data RAM, deliberately not reset so contents survive a core reset
    always_ff @(posedge clk) begin
        if (ramWe) ram[ramIdx] <= WriteDataM;
    end

    // free-running timer; a set from a match beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tCount   <= '0;
            tCmp     <= '0;
            IrqTimer <= 1'b0;
        end else begin
            tCount <= tCountWe ? WriteDataM : tCount + 32'd1;
            if (tCmpWe) tCmp <= WriteDataM;
            if (tCount == tCmp) IrqTimer <= 1'b1;
            else if (tStatClr) IrqTimer <= 1'b0;
        end
    end

    // FIFO storage, discarded on reset through the pointers alone
    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtr] <= WriteDataM[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
            if (pop) rdPtr <= rdPtr + PTR_W'(1);
            if (pushOk && !pop) fifoCount <= fifoCount + CNT_W'(1);
            else if (!pushOk && pop) fifoCount <= fifoCount - CNT_W'(1);
            if (pushReq && !pushOk) overflow <= 1'b1;
            else if (ustatClr) overflow <= 1'b0;
        end
    end

    // transmitter state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= stateNext;
    end

    // transmitter next state and FIFO pop
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    stateNext = START;
                end
            end
            START:   if (bitDone) stateNext = DATA;
            DATA:    if (bitDone && bitCnt == 3'd7) stateNext = STOP;
            STOP:    if (bitDone) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // bit timing, shifter and registered line level chosen for the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divCnt   <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            txdReg   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    divCnt <= '0;
                    if (pop) begin
                        shiftReg <= fifoMem[rdPtr];
                        bitCnt   <= '0;
                        txdReg   <= 1'b0;
                    end else begin
                        txdReg <= 1'b1;
                    end
                end
                START: begin
                    if (bitDone) begin
                        divCnt <= '0;
                        txdReg <= shiftReg[0];
                    end else begin
                        divCnt <= divCnt + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bitDone) begin
                        divCnt   <= '0;
                        shiftReg <= shiftReg >> 1;
                        bitCnt   <= bitCnt + 3'd1;
                        txdReg   <= (bitCnt == 3'd7) ? 1'b1 : shiftReg[1];
                    end else begin
                        divCnt <= divCnt + DIV_W'(1);
                    end
                end
                default: begin
                    txdReg <= 1'b1;
                    if (bitDone) divCnt <= '0;
                    else divCnt <= divCnt + DIV_W'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_mmio.sv
// tb/tb_mem_mmio.sv - self-checking bench for mem_mmio
module tb_mem_mmio;
    localparam int RAM_WORDS  = 64;
    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 10 * CLK_DIV;
    localparam int PERIOD     = FRAME + 1;

    localparam logic [31:0] A_TCOUNT = 32'hFFFF_0000;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_0004;
    localparam logic [31:0] A_TSTAT  = 32'hFFFF_0008;
    localparam logic [31:0] A_UDATA  = 32'hFFFF_0010;
    localparam logic [31:0] A_USTAT  = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ReadDataM;
    logic        TxD;
    logic        IrqTimer;

    int checks = 0;
    int fails = 0;

    logic [31:0] ramModel [RAM_WORDS];
    bit          ramKnown [RAM_WORDS];
    logic        txLog[$];
    logic        busyLog[$];
    bit          logEn = 1'b0;
    bit          logBusy = 1'b0;

    mem_mmio #(.RAM_WORDS(RAM_WORDS), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM),
        .MemWriteM(MemWriteM),
        .ReadDataM(ReadDataM),
        .TxD(TxD),
        .IrqTimer(IrqTimer)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (logEn) begin
            txLog.push_back(TxD);
            if (logBusy) busyLog.push_back(ReadDataM[2]);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        ALUOutM = a;
        WriteDataM = d;
        MemWriteM = 1'b1;
        tick();
        MemWriteM = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        ALUOutM = a;
        MemWriteM = 1'b0;
        #1;
        d = ReadDataM;
    endtask

    // line level s cycles after the first push: one idle cycle, then frames of
    // start + 8 data (LSB first) + stop, each frame followed by one idle cycle
    function automatic logic expTx(input logic [7:0] bytes[$], input int s);
        int j;
        int p;
        logic [7:0] b;
        if (s <= 0) return 1'b1;
        j = (s - 1) / PERIOD;
        p = (s - 1) % PERIOD;
        if (j >= bytes.size()) return 1'b1;
        if (p >= FRAME) return 1'b1;
        b = bytes[j];
        if (p / CLK_DIV == 0) return 1'b0;
        if (p / CLK_DIV == 9) return 1'b1;
        return b[p / CLK_DIV - 1];
    endfunction

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (TxD !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b want 1", TxD); end
        checks++;
        if (IrqTimer !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", IrqTimer); end
        reset = 1'b1;
        busRead(A_USTAT, rd);
        checks++;
        if (rd !== 32'h2) begin fails++; $display("FAIL reset_ustat: got %h want 00000002", rd); end
        busRead(A_TSTAT, rd);
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL reset_tstat: got %h want 00000000", rd); end
        busRead(32'h1234_0000, rd);
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL reset_unmapped: got %h want 00000000", rd); end
        busRead(A_TCMP, rd);
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL reset_tcmp: got %h want 00000000", rd); end
        busRead(A_TCOUNT, rd);
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL reset_tcount: got %h want 00000000", rd); end
        tick();
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d;
        int w;
        int bad;
        busWrite(32'h8, 32'hDEAD_BEEF);
        ramModel[2] = 32'hDEAD_BEEF;
        ramKnown[2] = 1'b1;
        busRead(32'h8, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_load8: got %h want deadbeef", rd); end
        busRead(32'hB, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_loadB: got %h want deadbeef", rd); end
        tick();

        // stores outside the RAM window must not alias onto it
        busWrite(32'h8000, 32'h1111_1111);
        busWrite(32'h0000_0100, 32'h2222_2222);
        busWrite(32'h8000_0008, 32'h3333_3333);
        busWrite(32'hFFFF_000C, 32'h4444_4444);
        busRead(32'h8000, rd);
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL ram_unmapped_load: got %h want 00000000", rd); end
        busRead(32'h0000_0100, rd);
        checks++;
        if (rd !== 32'h0) begin fails++; $display("FAIL ram_past_end_load: got %h want 00000000", rd); end
        busRead(32'h8, rd);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_no_alias: got %h want deadbeef", rd); end
        tick();

        // random stores, some with a same-cycle load of the old value
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            w = $urandom_range(0, RAM_WORDS - 1);
            a = 32'(w * 4 + $urandom_range(0, 3));
            d = $urandom;
            ALUOutM = a;
            WriteDataM = d;
            MemWriteM = 1'b1;
            #1;
            if (ramKnown[w] && ReadDataM !== ramModel[w]) bad++;
            tick();
            MemWriteM = 1'b0;
            ramModel[w] = d;
            ramKnown[w] = 1'b1;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL ram_same_cycle_old: got %0d stale mismatches want 0", bad); end

        busRead(32'h0000_00FC, rd);
        checks++;
        if (ramKnown[RAM_WORDS-1] && rd !== ramModel[RAM_WORDS-1]) begin
            fails++; $display("FAIL ram_last_word: got %h want %h", rd, ramModel[RAM_WORDS-1]);
        end
        tick();

        bad = 0;
        for (int i = 0; i < RAM_WORDS; i++) begin
            busRead(32'(i * 4), rd);
            if (ramKnown[i] && rd !== ramModel[i]) begin
                bad++;
                $display("word %0d read %h model %h", i, rd, ramModel[i]);
            end
            tick();
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL ram_random_readback: got %0d bad words want 0", bad); end
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        logic [31:0] loadVal;
        logic [31:0] v;
        int expRise;
        int rise;
        int early;

        busWrite(A_TCOUNT, 32'd1000);
        busWrite(A_TCMP, 32'd20);
        busWrite(A_TSTAT, 32'd1);
        checks++;
        if (IrqTimer !== 1'b0) begin fails++; $display("FAIL timer_clear: got %b want 0", IrqTimer); end
        busRead(A_TCMP, rd);
        checks++;
        if (rd !== 32'd20) begin fails++; $display("FAIL timer_tcmp_read: got %0d want 20", rd); end

        loadVal = 32'd10;
        busWrite(A_TCOUNT, loadVal);
        busRead(A_TCOUNT, rd);
        checks++;
        if (rd !== loadVal) begin fails++; $display("FAIL timer_tcount_load: got %0d want %0d", rd, loadVal); end
        // the flag appears on the edge following the cycle whose count equals the compare value
        expRise = -1;
        for (int k = 1; k <= 15; k++) begin
            v = loadVal + 32'(k - 1);
            if (expRise < 0 && v == 32'd20) expRise = k;
        end
        rise = -1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (rise < 0 && IrqTimer === 1'b1) rise = k;
        end
        checks++;
        if (rise != expRise) begin fails++; $display("FAIL timer_rise_edge: got %0d want %0d", rise, expRise); end
        busRead(A_TCOUNT, rd);
        checks++;
        if (rd !== loadVal + 32'd15) begin fails++; $display("FAIL timer_count_run: got %0d want %0d", rd, loadVal + 32'd15); end

        busWrite(A_TSTAT, 32'd1);
        checks++;
        if (IrqTimer !== 1'b0) begin fails++; $display("FAIL timer_tstat_clear: got %b want 0", IrqTimer); end

        loadVal = 32'hFFFF_FFF0;
        busWrite(A_TCOUNT, loadVal);
        expRise = -1;
        for (int k = 1; k <= 45; k++) begin
            v = loadVal + 32'(k - 1);
            if (expRise < 0 && v == 32'd20) expRise = k;
        end
        rise = -1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (rise < 0 && IrqTimer === 1'b1) rise = k;
            if (k == 16) begin
                busRead(A_TCOUNT, rd);
                checks++;
                if (rd !== loadVal + 32'd16) begin fails++; $display("FAIL timer_wrap_count: got %h want %h", rd, loadVal + 32'd16); end
            end
        end
        checks++;
        if (rise != expRise) begin fails++; $display("FAIL timer_wrap_rise: got %0d want %0d", rise, expRise); end

        // clear in the very cycle of a match loses to the set
        busWrite(A_TCMP, 32'd500);
        busWrite(A_TSTAT, 32'd1);
        early = IrqTimer;
        checks++;
        if (early != 0) begin fails++; $display("FAIL timer_pre_collision: got %0d want 0", early); end
        busWrite(A_TCOUNT, 32'd500);
        busWrite(A_TSTAT, 32'd1);
        checks++;
        if (IrqTimer !== 1'b1) begin fails++; $display("FAIL timer_set_wins: got %b want 1", IrqTimer); end
        busWrite(A_TSTAT, 32'd1);
        checks++;
        if (IrqTimer !== 1'b0) begin fails++; $display("FAIL timer_clear_after: got %b want 0", IrqTimer); end
        busWrite(A_TCMP, 32'h7FFF_FFFF);
    endtask

    task automatic test_uart_frame();
        logic [7:0] sent[$];
        logic [7:0] b;
        logic [31:0] rd;
        logic [FRAME+3:0] actV;
        logic [FRAME+3:0] expV;
        logic [FRAME+3:0] actB;
        logic [FRAME+3:0] expB;
        for (int n = 0; n < 3; n++) begin
            b = (n == 0) ? 8'hA5 : 8'($urandom);
            sent.delete();
            sent.push_back(b);
            txLog.delete();
            busyLog.delete();
            busWrite(A_UDATA, {24'h0, b});
            ALUOutM = A_USTAT;
            logEn = 1'b1;
            logBusy = 1'b1;
            repeat (FRAME + 4) tick();
            logEn = 1'b0;
            logBusy = 1'b0;
            checks++;
            if (txLog.size() != FRAME + 4 || busyLog.size() != FRAME + 4) begin
                fails++; $display("FAIL frame_log_len: got %0d want %0d", txLog.size(), FRAME + 4);
            end else begin
                for (int s = 0; s < FRAME + 4; s++) begin
                    actV[s] = txLog[s];
                    expV[s] = expTx(sent, s);
                    actB[s] = busyLog[s];
                    expB[s] = (s >= 1 && s <= FRAME);
                end
                checks++;
                if (actV !== expV) begin fails++; $display("FAIL frame_txd byte %h: got %h want %h", b, actV, expV); end
                checks++;
                if (actB !== expB) begin fails++; $display("FAIL frame_busy byte %h: got %h want %h", b, actB, expB); end
            end
            busRead(A_USTAT, rd);
            checks++;
            if (rd !== 32'h2) begin fails++; $display("FAIL frame_ustat_after: got %h want 00000002", rd); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pushed[$];
        logic [7:0] accepted[$];
        logic [31:0] rd;
        logic [31:0] expStat;
        logic [FRAME:0] actW;
        logic [FRAME:0] expW;
        int occ;
        int dropped;
        int tailBad;
        bit popNow;
        bit acc;

        for (int i = 0; i < 6; i++) pushed.push_back(8'($urandom));
        // the transmitter takes the first byte one cycle after it lands, then is busy for a whole frame
        occ = 0;
        dropped = 0;
        for (int i = 0; i < 6; i++) begin
            popNow = (i == 1);
            acc = (occ < FIFO_DEPTH) || popNow;
            if (acc) begin accepted.push_back(pushed[i]); occ++; end
            else dropped++;
            if (popNow) occ--;
        end
        expStat = {28'h0, dropped > 0, 1'b1, occ == 0, occ == FIFO_DEPTH};

        txLog.delete();
        busWrite(A_UDATA, {24'h0, pushed[0]});
        logEn = 1'b1;
        for (int i = 1; i < 6; i++) busWrite(A_UDATA, {24'h0, pushed[i]});
        busRead(A_USTAT, rd);
        checks++;
        if (rd !== expStat) begin fails++; $display("FAIL b2b_ustat_full: got %h want %h", rd, expStat); end
        repeat (6 * PERIOD + 10) tick();
        logEn = 1'b0;

        checks++;
        if (txLog.size() < 6 * PERIOD + 1) begin
            fails++; $display("FAIL b2b_log_len: got %0d want at least %0d", txLog.size(), 6 * PERIOD + 1);
        end else begin
            checks++;
            if (txLog[0] !== 1'b1) begin fails++; $display("FAIL b2b_lead_idle: got %b want 1", txLog[0]); end
            for (int j = 0; j < accepted.size(); j++) begin
                for (int p = 0; p <= FRAME; p++) begin
                    actW[p] = txLog[1 + PERIOD * j + p];
                    expW[p] = expTx(accepted, 1 + PERIOD * j + p);
                end
                checks++;
                if (actW !== expW) begin fails++; $display("FAIL b2b_frame%0d: got %h want %h", j, actW, expW); end
            end
            tailBad = 0;
            for (int s = 1 + PERIOD * accepted.size(); s < txLog.size(); s++) if (txLog[s] !== 1'b1) tailBad++;
            checks++;
            if (tailBad != 0) begin fails++; $display("FAIL b2b_dropped_not_sent: got %0d low samples want 0", tailBad); end
        end

        busWrite(A_USTAT, 32'h7);
        busRead(A_USTAT, rd);
        checks++;
        if (rd !== 32'hA) begin fails++; $display("FAIL b2b_ovf_kept: got %h want 0000000a", rd); end
        tick();
        busWrite(A_USTAT, 32'h8);
        busRead(A_USTAT, rd);
        checks++;
        if (rd !== 32'h2) begin fails++; $display("FAIL b2b_ovf_clear: got %h want 00000002", rd); end
        tick();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic [31:0] d;
        int w;
        int bad;
        w = $urandom_range(0, RAM_WORDS - 1);
        d = $urandom;
        busWrite(32'(w * 4), d);
        ramModel[w] = d;
        ramKnown[w] = 1'b1;
        busWrite(A_UDATA, 32'h00);
        busWrite(A_UDATA, 32'h11);
        busWrite(A_UDATA, 32'h22);
        repeat (12) tick();
        checks++;
        if (TxD !== 1'b0) begin fails++; $display("FAIL midframe_low: got %b want 0", TxD); end
        reset = 1'b0;
        #1;
        checks++;
        if (TxD !== 1'b1) begin fails++; $display("FAIL midframe_async_txd: got %b want 1", TxD); end
        tick();
        tick();
        reset = 1'b1;
        busRead(A_USTAT, rd);
        checks++;
        if (rd !== 32'h2) begin fails++; $display("FAIL midframe_ustat: got %h want 00000002", rd); end
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (TxD !== 1'b1 || ReadDataM !== 32'h2) bad++;
        end
        checks++;
        if (bad != 0) begin fails++; $display("FAIL midframe_fifo_discarded: got %0d bad cycles want 0", bad); end
        busRead(32'(w * 4), rd);
        checks++;
        if (rd !== d) begin fails++; $display("FAIL midframe_ram_kept: got %h want %h", rd, d); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < RAM_WORDS; i++) begin
            ramModel[i] = '0;
            ramKnown[i] = 1'b0;
        end
        test_reset();
        test_ram();
        test_timer();
        test_uart_frame();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
